// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
package sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: diff = a - b - bin, bout = borrow out.
// Ports: a, b, bin in; diff, bout out. Purely combinational.
module full_sub (
  input  logic a,
  input  logic b,
  output logic diff,
  input  logic bin,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b over WIDTH cycles, LSB first, via one full_sub.
// Ports: clk, rst, start, a, b in; busy, done, diff, bout out.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             cdiff;
  logic             cbout;
  logic             last;

  full_sub u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .diff (cdiff),
    .bin  (brw),
    .bout (cbout)
  );

  assign last  = (cnt == CW'(WIDTH - 1));
  // r_sh keeps the bits already produced; the new bit enters at the MSB
  assign r_nxt = {cdiff, r_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt[WIDTH-1:1];
          brw  <= cbout;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff <= r_nxt;
            bout <= cbout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH 8, 4 and 16.
// WIDTH 8 is tracked every cycle against a timing/arithmetic model.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16, done16, bout16;
  logic [15:0] diff16;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  serial_sub_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Model: m_t counts edges since the accepting edge, -1 when idle.
  // busy for t in 0..7, done at t == 8, result lands on edge t=8.
  int         m_t = -1;
  logic [7:0] m_a, m_b;
  logic [7:0] m_diff = '0;
  logic       m_bout = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t    <= -1;
      m_diff <= '0;
      m_bout <= 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t <= 0;
        m_a <= a;
        m_b <= b;
      end
    end else begin
      m_t <= (m_t == 8) ? -1 : m_t + 1;
      if (m_t == 7) begin
        m_diff <= 8'((int'(m_a) - int'(m_b)) & 255);
        m_bout <= (int'(m_a) < int'(m_b));
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en)
      chk("cycle8", {busy, done, bout, diff},
          {(m_t >= 0 && m_t < 8), (m_t == 8), m_bout, m_diff});
  end

  // Run one WIDTH-8 op, pin busy length, single done and result.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb);
    int nb = 0;
    int nd = 0;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv;
    for (int i = 0; i < 12; i++) begin
      nb += int'(busy);
      nd += int'(done);
      @(negedge clk);
    end
    chk("busy_len", 64'(nb), 64'd8);
    chk("done_cnt", 64'(nd), 64'd1);
    chk("diff8", 64'(diff), 64'(ed));
    chk("bout8", 64'(bout), 64'(eb));
  endtask

  initial begin
    int nd;
    bit got;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_diff", 64'({bout, diff}), 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    run8(8'd9, 8'd5, 8'd4, 1'b0);
    run8(8'd5, 8'd9, 8'hFC, 1'b1);
    run8(8'd0, 8'd0, 8'h00, 1'b0);
    run8(8'hFF, 8'h01, 8'hFE, 1'b0);
    run8(8'h00, 8'hFF, 8'h01, 1'b1);

    // start re-asserted in RUN (cycles 3, 8) and in DONE (cycle 9)
    @(negedge clk);
    start = 1'b1; a = 8'd20; b = 8'd3;
    @(negedge clk);
    nd = 0;
    for (int i = 1; i <= 14; i++) begin
      start = (i == 3 || i == 8 || i == 9);
      a = 8'd1; b = 8'd200;
      nd += int'(done);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_done", 64'(nd), 64'd1);
    chk("ign_diff", 64'({bout, diff}), 64'd17);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_res", 64'({bout, diff}), 64'd0);
    nd = 0;
    repeat (10) begin
      nd += int'(done);
      @(negedge clk);
    end
    chk("mid_nodone", 64'(nd), 64'd0);
    run8(8'd7, 8'd7, 8'd0, 1'b0);

    // start held high: accepts on edges 1, 11, 21
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      start = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      nd += int'(done);
    end
    start = 1'b0;
    chk("b2b_dones", 64'(nd), 64'd3);
    repeat (12) @(negedge clk);

    // WIDTH 4: every operand pair
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        start4 = 1'b1; a4 = 4'(x); b4 = 4'(y);
        @(negedge clk);
        start4 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          if (done4) got = 1'b1;
          else @(negedge clk);
        end
        chk("w4_done", 64'(got), 64'd1);
        chk("w4_res", 64'({bout4, diff4}),
            64'({(x < y), 4'((x - y) & 15)}));
        @(negedge clk);
      end
    end

    // WIDTH 16: random spot checks
    for (int n = 0; n < 10; n++) begin
      int x, y;
      x = int'($urandom_range(0, 65535));
      y = int'($urandom_range(0, 65535));
      start16 = 1'b1; a16 = 16'(x); b16 = 16'(y);
      @(negedge clk);
      start16 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        if (done16) got = 1'b1;
        else @(negedge clk);
      end
      chk("w16_done", 64'(got), 64'd1);
      chk("w16_res", 64'({bout16, diff16}),
          64'({(x < y), 16'((x - y) & 65535)}));
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller: computes a - b (unsigned, WIDTH bits) by sequencing one 1-bit full_sub cell over WIDTH clock cycles, LSB first.
- The borrow from each bit feeds back into the next bit through a flop.
- Sits beside the full_sub cell in the arithmetic library as the area-cheap alternative to a ripple array of WIDTH full_sub instances.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: diff and bout valid and newly updated.
- diff  output  WIDTH  result a - b mod 2^WIDTH; held until the next completion.
- bout  output  1  final borrow; 1 iff a < b (unsigned); held with diff.

Behaviour:
- Reset (rst=1 at an edge, regardless of state):
  - state=IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Internal operand shifters, borrow flop and counter cleared.
  - Takes priority over start.
- States: IDLE, RUN, DONE. Encodings come from the shared package.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: a_sh<=a, b_sh<=b, brw<=0, cnt<=0, state<=RUN.
  - With start=0: stay in IDLE.
- RUN:
  - busy=1.
  - full_sub inputs: a=a_sh[0], b=b_sh[0], bin=brw.
  - Each edge:
    - cell diff shifts into r_sh at the MSB; r_sh shifts right.
    - a_sh and b_sh shift right.
    - brw<=cell bout.
    - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1:
    - load diff<=final r_sh value, including this bit.
    - load bout<=cell bout.
    - state<=DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge goes unconditionally to IDLE.
  - start is ignored in DONE.
- Latency and throughput:
  - Start accepted at edge E0; done is high in the cycle following edge E0+WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy or in DONE: ignored. Operands are not resampled and the in-flight computation is unaffected.
- a and b may change freely after the accepting edge; only the latched copies are used.
- diff and bout change only on the completion edge or on reset. A new start does not clear them.
- Reset mid-RUN: the computation is aborted, diff/bout clear to 0, and no done pulse is issued.
- Arithmetic: diff = (a - b) mod 2^WIDTH and bout = (a < b), bit-exact against the parallel reference model, for all operands.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package sub_pkg contains:
  - state typedef {IDLE, RUN, DONE}, 2-bit encoding.
  - default WIDTH constant.
- Sub-module: the existing full_sub cell, instantiated once, port order (a, b, diff, bin, bout).
  - It is the only arithmetic in the block.
  - The controller holds all sequencing, shift registers and the borrow flop.

Test Plan:
- Basic subtraction: WIDTH=8, a=9, b=5, start pulsed one cycle at E0.
  - busy high for 8 cycles.
  - done high for exactly 1 cycle after E0+8.
  - diff=8'd4, bout=0.
- Underflow: a=5, b=9 -> diff=8'hFC, bout=1. Then a=0, b=0 -> diff=0, bout=0. Then a=8'hFF, b=8'h01 -> diff=8'hFE, bout=0. Then a=8'h00, b=8'hFF -> diff=8'h01, bout=1.
- Start ignored and inputs latched: start a=20, b=3; re-assert start with a=1, b=200 at cycles 3 and 8 (in RUN) and in the DONE cycle.
  - Exactly one done pulse; diff=8'd17, bout=0.
  - Changing a/b after E0 does not affect the result.
- Reset mid-operation: start a=100, b=50; assert rst for 1 cycle at RUN cycle 4.
  - Next cycle: busy=0, diff=0, bout=0, no done.
  - A fresh start a=7, b=7 then gives diff=0, bout=0 with normal latency.
- Back-to-back operations: start held continuously high for 30 cycles with operands changing each cycle.
  - A new operation is accepted every WIDTH+2 cycles, each in IDLE.
  - Each done's diff/bout matches the operands present on its accepting edge.
  - diff holds between done pulses.
- Exhaustive check: WIDTH=4, all 256 (a, b) pairs, compared against (a-b) mod 16 and (a<b).
  - Also spot-check WIDTH=16 with random operands against the reference model.
